// File: rtl/fft_feed_pkg.sv
// Shared constants and types for the FFT frame feeder: default geometry,
// read-side FSM encoding and the fixed FFT control values.
package fft_feed_pkg;

  localparam int FFT_PTS_DEF = 256;
  localparam int ADDR_W_DEF  = 8;
  localparam int IN_W_DEF    = 16;
  localparam int DATA_W_DEF  = 24;
  localparam int FFTPTS_W    = 9;
  localparam int FRAMES_W    = 16;

  localparam logic [1:0] SINK_ERR_NONE = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    PREFETCH,
    STREAM
  } rd_state_e;

endpackage

// File: rtl/frame_bank_ram.sv
// Simple dual-port RAM holding both ping-pong banks; registered read so the
// array maps onto a block RAM. The read register holds when i_re is low.
module frame_bank_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 512,
  parameter int AW     = 9
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fft_frame_feeder.sv
// Collects audio samples into a ping-pong frame buffer and streams each full
// frame to the FFT Avalon-ST sink with sop/eop framing and backpressure.
module fft_frame_feeder
  import fft_feed_pkg::*;
#(
  parameter int IN_W    = IN_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int FFT_PTS = FFT_PTS_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sample_valid,
  input  logic [IN_W-1:0]     sample_data,
  output logic                sink_valid,
  input  logic                sink_ready,
  output logic                sink_sop,
  output logic                sink_eop,
  output logic [DATA_W-1:0]   sink_real,
  output logic [DATA_W-1:0]   sink_imag,
  output logic [1:0]          sink_error,
  output logic [FFTPTS_W-1:0] fftpts_in,
  output logic                inverse,
  output logic                overrun,
  output logic [FRAMES_W-1:0] frames_sent
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FFT_PTS - 1);

  rd_state_e r_state;
  rd_state_e w_state_nxt;

  logic [1:0]          r_full;
  logic                r_wb;
  logic                r_rb;
  logic [ADDR_W-1:0]   r_wr_idx;
  logic [ADDR_W-1:0]   r_rd_idx;
  logic                r_overrun;
  logic [FRAMES_W-1:0] r_frames;

  logic                w_wr_ok;
  logic                w_wr_last;
  logic                w_set_full;
  logic                w_accept;
  logic                w_rd_last;
  logic                w_release;
  logic [1:0]          w_set_mask;
  logic [1:0]          w_clr_mask;
  logic [ADDR_W-1:0]   w_rd_idx_nxt;
  logic                w_rd_en;
  logic [ADDR_W:0]     w_rd_addr;
  logic [IN_W-1:0]     w_rdata;

  // Write-side decisions use the pre-update full flag, so a sample arriving
  // as the reader frees the write bank is still dropped.
  assign w_wr_ok    = sample_valid && !r_full[r_wb];
  assign w_wr_last  = (r_wr_idx == LAST_IDX);
  assign w_set_full = w_wr_ok && w_wr_last;

  assign w_accept     = sink_valid && sink_ready;
  assign w_rd_last    = (r_rd_idx == LAST_IDX);
  assign w_release    = w_accept && w_rd_last;
  assign w_rd_idx_nxt = r_rd_idx + 1'b1;

  assign w_set_mask = w_set_full ? (2'b01 << r_wb) : '0;
  assign w_clr_mask = w_release  ? (2'b01 << r_rb) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_idx  <= '0;
      r_wb      <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_wr_ok) begin
      r_wr_idx <= r_wr_idx + 1'b1;
      if (w_wr_last) begin
        r_wb <= ~r_wb;
      end
    end else if (sample_valid) begin
      r_overrun <= 1'b1;
    end
  end

  // Writer and reader never target the same bank in one cycle, so the set
  // and clear masks are disjoint and both updates land together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_full <= '0;
    end else begin
      r_full <= (r_full | w_set_mask) & ~w_clr_mask;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_idx <= '0;
      r_rb     <= 1'b0;
      r_frames <= '0;
    end else begin
      if (r_state == IDLE) begin
        r_rd_idx <= '0;
      end else if (w_accept && !w_rd_last) begin
        r_rd_idx <= w_rd_idx_nxt;
      end
      if (w_release) begin
        r_rb     <= ~r_rb;
        r_frames <= r_frames + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:     if (r_full[r_rb]) w_state_nxt = PREFETCH;
      PREFETCH: w_state_nxt = w_release ? IDLE : STREAM;
      STREAM:   if (w_release) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  // PREFETCH is the first presentation cycle; the beat can already be
  // accepted there, which keeps the bank-full to valid latency at two cycles.
  always_comb begin
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    sink_eop   = 1'b0;
    unique case (r_state)
      PREFETCH, STREAM: begin
        sink_valid = 1'b1;
        sink_sop   = (r_rd_idx == '0);
        sink_eop   = w_rd_last;
      end
      default: ;
    endcase
  end

  // Show-ahead read: the next point is fetched on acceptance, and the RAM
  // read register holds the current point untouched while stalled.
  always_comb begin
    w_rd_en   = 1'b0;
    w_rd_addr = {r_rb, {ADDR_W{1'b0}}};
    if (r_state == IDLE) begin
      w_rd_en = r_full[r_rb];
    end else if (w_accept && !w_rd_last) begin
      w_rd_en   = 1'b1;
      w_rd_addr = {r_rb, w_rd_idx_nxt};
    end
  end

  frame_bank_ram #(
    .DATA_W (IN_W),
    .DEPTH  (2 * FFT_PTS),
    .AW     (ADDR_W + 1)
  ) u_ram (
    .i_clk   (clk),
    .i_we    (w_wr_ok),
    .i_waddr ({r_wb, r_wr_idx}),
    .i_wdata (sample_data),
    .i_re    (w_rd_en),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rdata)
  );

  assign sink_real   = sink_valid ? {{(DATA_W-IN_W){w_rdata[IN_W-1]}}, w_rdata} : '0;
  assign sink_imag   = '0;
  assign sink_error  = SINK_ERR_NONE;
  assign fftpts_in   = FFTPTS_W'(FFT_PTS);
  assign inverse     = 1'b0;
  assign overrun     = r_overrun;
  assign frames_sent = r_frames;

endmodule
